// File: rtl/mux_stream_pkg.sv
// rtl/mux_stream_pkg.sv - shared constants, output-stage state type and index helper
package mux_stream_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {EMPTY, FULL} state_t;

  // (a + b) mod n for operands already below n
  function automatic int wrap_add(int a, int b, int n);
    int t;
    t = a + b;
    return (t >= n) ? t - n : t;
  endfunction

endpackage

// File: rtl/mux_rr_stream_if.sv
// rtl/mux_rr_stream_if.sv - input channels, select controls and output stream of the mux
interface mux_rr_stream_if #(
  parameter int WIDTH    = 3,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [SEL_W-1:0]          s;
  logic                      mode;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;

  modport slave (
    input  in_data, in_valid, s, mode, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

  modport master (
    output in_data, in_valid, s, mode, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/mux_rr_stream_rr_arbiter.sv
// rtl/mux_rr_stream_rr_arbiter.sv - round-robin arbiter owning the rotating priority pointer
module rr_arbiter
  import mux_stream_pkg::*;
#(
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] req,
  input  logic                advance,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx,
  output logic                any_grant
);

  logic [SEL_W-1:0]      ptr;
  logic [2*CHANNELS-1:0] rotated;

  // Bit k of rotated is the request of channel (ptr + k) mod CHANNELS
  assign rotated = {req, req} >> ptr;

  always_comb begin
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!any_grant && rotated[k]) begin
        any_grant = 1'b1;
        grant_idx = SEL_W'(wrap_add(int'(ptr), k, CHANNELS));
      end
    end
    grant = any_grant ? (CHANNELS'(1) << grant_idx) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && any_grant) begin
      ptr <= SEL_W'(wrap_add(int'(grant_idx), 1, CHANNELS));
    end
  end

endmodule

// File: rtl/mux_rr_stream.sv
// rtl/mux_rr_stream.sv - N-channel stream mux, fixed or round-robin select, one registered output stage
module mux_rr_stream
  import mux_stream_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int CHANNELS = 4
) (
  input logic            clk,
  input logic            rst,
  mux_rr_stream_if.slave bus
);

  localparam int SEL_W = $clog2(CHANNELS);

  state_t              state;
  logic [WIDTH-1:0]    data_q;
  logic [SEL_W-1:0]    chan_q;
  logic                load_en;
  logic [CHANNELS-1:0] rr_grant;
  logic [SEL_W-1:0]    rr_idx;
  logic                rr_any;
  logic [CHANNELS-1:0] fix_grant;
  logic                fix_any;
  logic                sel_any;
  logic [SEL_W-1:0]    sel_idx;
  logic [WIDTH-1:0]    sel_data;

  assign load_en = (state == EMPTY) || bus.out_ready;

  rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.in_valid),
    .advance   (load_en && (bus.mode == MODE_RR)),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .any_grant (rr_any)
  );

  // Compare against each legal index so an out-of-range s simply matches nothing
  always_comb begin
    fix_grant = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      fix_grant[i] = (bus.s == SEL_W'(i)) && bus.in_valid[i];
    end
  end

  assign fix_any = |fix_grant;
  assign sel_any = (bus.mode == MODE_FIXED) ? fix_any : rr_any;
  assign sel_idx = (bus.mode == MODE_FIXED) ? bus.s : rr_idx;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel_idx == SEL_W'(i)) sel_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    bus.in_ready = '0;
    if (!rst && load_en) bus.in_ready = (bus.mode == MODE_FIXED) ? fix_grant : rr_grant;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      data_q <= '0;
      chan_q <= '0;
    end else if (load_en) begin
      if (sel_any) begin
        state  <= FULL;
        data_q <= sel_data;
        chan_q <= sel_idx;
      end else begin
        state  <= EMPTY;
      end
    end
  end

  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;

endmodule
